// File: rtl/snake_pkg.sv
// Shared constants and codes for the snake game blocks.
package snake_pkg;

  localparam int GRID_COLS  = 7;
  localparam int GRID_ROWS  = 6;
  localparam int CELL_COUNT = GRID_COLS * GRID_ROWS;
  localparam int IDX_W      = 6;
  localparam int XY_W       = 3;
  localparam int LFSR_W     = 8;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    GS_IDLE,
    GS_RUNNING,
    GS_GAME_FINISHED,
    GS_CLEANUP
  } game_state_e;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_SCAN,
    SP_FULL
  } spawn_state_e;

  // Linear cell index y*cols+x built from shifted adds of the row bits.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [XY_W-1:0] x,
                                                input logic [XY_W-1:0] y,
                                                input logic [IDX_W-1:0] cols);
    logic [IDX_W-1:0] acc;
    acc = {{(IDX_W-XY_W){1'b0}}, x};
    for (int b = 0; b < XY_W; b++) begin
      if (y[b]) acc = acc + (cols << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/snake_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module snake_lfsr8
  import snake_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  output logic [LFSR_W-1:0] o_State
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  assign lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign o_State = lfsr_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/snake_food_spawner.sv
// Picks the next free food cell: scans the board one cell per cycle from a
// pseudo-random start, using a snapshot of the snake occupancy.
module snake_food_spawner #(
  parameter int         GRID_COLS    = 7,
  parameter int         GRID_ROWS    = 6,
  parameter logic [7:0] LFSR_SEED    = 8'hA5,
  parameter int         RESET_FOOD_X = 6,
  parameter int         RESET_FOOD_Y = 3
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_Spawn_Req,
  input  logic [GRID_COLS*GRID_ROWS-1:0]   i_Snake_Body,
  input  logic [snake_pkg::IDX_W-1:0]      i_Exclude_Idx,
  output logic [snake_pkg::XY_W-1:0]       o_Food_X,
  output logic [snake_pkg::XY_W-1:0]       o_Food_Y,
  output logic                             o_Food_Valid,
  output logic                             o_Busy,
  output logic                             o_Board_Full
);

  localparam int IDX_W = snake_pkg::IDX_W;
  localparam int XY_W  = snake_pkg::XY_W;
  localparam int CELLS = GRID_COLS * GRID_ROWS;

  localparam logic [XY_W-1:0]  COLS_XY  = XY_W'(GRID_COLS);
  localparam logic [XY_W-1:0]  ROWS_XY  = XY_W'(GRID_ROWS);
  localparam logic [IDX_W-1:0] COLS_IDX = IDX_W'(GRID_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  typedef snake_pkg::spawn_state_e state_e;

  state_e             state_q, state_d;
  logic [CELLS-1:0]   body_q, body_d;
  logic [IDX_W-1:0]   excl_q, excl_d;
  logic [XY_W-1:0]    x_q, x_d, y_q, y_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [XY_W-1:0]    food_x_q, food_x_d, food_y_q, food_y_d;
  logic               valid_q, valid_d, busy_q, busy_d, full_q, full_d;

  logic [7:0]         lfsr;
  logic [XY_W-1:0]    raw_x, raw_y, start_x, start_y;
  logic [IDX_W-1:0]   start_idx;
  logic               occupied;
  logic               unused_lfsr_hi;

  snake_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .o_State(lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:6];
  assign raw_x     = lfsr[2:0];
  assign raw_y     = lfsr[5:3];
  assign start_x   = (raw_x >= COLS_XY) ? raw_x - COLS_XY : raw_x;
  assign start_y   = (raw_y >= ROWS_XY) ? raw_y - ROWS_XY : raw_y;
  assign start_idx = snake_pkg::cell_idx(start_x, start_y, COLS_IDX);
  assign occupied  = body_q[idx_q] || (idx_q == excl_q);

  always_comb begin
    state_d  = state_q;
    body_d   = body_q;
    excl_d   = excl_q;
    x_d      = x_q;
    y_d      = y_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    full_d   = full_q;
    case (state_q)
      // FULL lasts one cycle with Busy already low, so it accepts requests like IDLE.
      snake_pkg::SP_IDLE, snake_pkg::SP_FULL: begin
        state_d = snake_pkg::SP_IDLE;
        if (i_Spawn_Req) begin
          body_d  = i_Snake_Body;
          excl_d  = i_Exclude_Idx;
          x_d     = start_x;
          y_d     = start_y;
          idx_d   = start_idx;
          cnt_d   = '0;
          full_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = snake_pkg::SP_SCAN;
        end
      end
      snake_pkg::SP_SCAN: begin
        if (!occupied) begin
          food_x_d = x_q;
          food_y_d = y_q;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = snake_pkg::SP_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (x_q == COLS_XY - 1'b1) begin
            x_d = '0;
            y_d = (y_q == ROWS_XY - 1'b1) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            full_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = snake_pkg::SP_FULL;
          end
        end
      end
      default: state_d = snake_pkg::SP_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= snake_pkg::SP_IDLE;
      body_q   <= '0;
      excl_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      food_x_q <= XY_W'(RESET_FOOD_X);
      food_y_q <= XY_W'(RESET_FOOD_Y);
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      body_q   <= body_d;
      excl_q   <= excl_d;
      x_q      <= x_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      full_q   <= full_d;
    end
  end

  assign o_Food_X     = food_x_q;
  assign o_Food_Y     = food_y_q;
  assign o_Food_Valid = valid_q;
  assign o_Busy       = busy_q;
  assign o_Board_Full = full_q;

endmodule

// File: tb/tb_snake_food_spawner.sv
// Bench for snake_food_spawner: a transaction-level reference model checked
// every cycle, plus directed cases with hand-derived expectations.
module tb_snake_food_spawner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [41:0] body = '0;
  logic [5:0]  excl = 6'd63;
  logic [2:0]  fx, fy;
  logic        fvalid, busy, full;

  int errors = 0;
  int checks = 0;

  snake_food_spawner dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Spawn_Req  (req),
    .i_Snake_Body (body),
    .i_Exclude_Idx(excl),
    .o_Food_X     (fx),
    .o_Food_Y     (fy),
    .o_Food_Valid (fvalid),
    .o_Busy       (busy),
    .o_Board_Full (full)
  );

  always #5 clk = ~clk;

  // Reference model: on an accepted request it searches the board for the
  // first free cell and schedules the answer k+1 edges later.
  logic [7:0] m_lfsr  = 8'hA5;
  logic [2:0] m_x     = 3'd6;
  logic [2:0] m_y     = 3'd3;
  logic       m_valid = 1'b0;
  logic       m_busy  = 1'b0;
  logic       m_full  = 1'b0;
  logic       m_found = 1'b0;
  int         m_rem   = 0;
  int         m_res   = 0;

  function automatic int start_of(input logic [7:0] l);
    int rx, ry;
    rx = int'(l[2:0]);
    ry = int'(l[5:3]);
    if (rx >= 7) rx -= 7;
    if (ry >= 6) ry -= 6;
    return ry * 7 + rx;
  endfunction

  function automatic logic [41:0] rand42();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[41:0];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr = 8'hA5; m_x = 3'd6; m_y = 3'd3;
      m_valid = 1'b0; m_busy = 1'b0; m_full = 1'b0; m_rem = 0;
    end else begin
      m_valid = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          if (m_found) begin
            m_x = 3'(m_res % 7);
            m_y = 3'(m_res / 7);
            m_valid = 1'b1;
          end else begin
            m_full = 1'b1;
          end
        end
      end else if (req) begin
        int s;
        s = start_of(m_lfsr);
        m_found = 1'b0;
        for (int k = 0; k < 42; k++) begin
          int c;
          c = (s + k) % 42;
          if (!m_found && !body[c] && c != int'(excl)) begin
            m_found = 1'b1;
            m_res = c;
            m_rem = k + 1;
          end
        end
        if (!m_found) m_rem = 42;
        m_busy = 1'b1;
        m_full = 1'b0;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (fx !== m_x || fy !== m_y || fvalid !== m_valid || busy !== m_busy || full !== m_full) begin
        errors++;
        $display("FAIL model t=%0t got x=%0d y=%0d v=%0b b=%0b f=%0b want x=%0d y=%0d v=%0b b=%0b f=%0b",
                 $time, fx, fy, fvalid, busy, full, m_x, m_y, m_valid, m_busy, m_full);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Issues a one-cycle request from a negedge; returns cycles until Valid or Full.
  task automatic do_req(input logic [41:0] b, input logic [5:0] e, output int lat, output int got);
    body = b; excl = e; req = 1'b1;
    @(negedge clk);
    req = 1'b0; lat = 1; got = 0;
    while (lat < 60) begin
      if (fvalid) begin got = 1; break; end
      if (full) break;
      @(negedge clk);
      lat++;
    end
    $display("req body=%h excl=%0d -> lat=%0d valid=%0d x=%0d y=%0d full=%0b", b, e, lat, got, fx, fy, full);
  endtask

  initial begin
    int lat, got, w, s, e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Empty board right after reset: LFSR A5 -> start (5,4).
    do_req('0, 6'd63, lat, got);
    chk("empty_lat", lat, 2); chk("empty_x", int'(fx), 5); chk("empty_y", int'(fy), 4);
    chk("empty_busy", int'(busy), 0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_x", int'(fx), 6); chk("rst_y", int'(fy), 3); chk("rst_valid", int'(fvalid), 0);
    chk("rst_busy", int'(busy), 0); chk("rst_full", int'(full), 0);
    @(negedge clk);
    rst = 1'b0;

    // Cells 33,34 occupied -> 35 = (0,5).
    do_req((42'd1 << 33) | (42'd1 << 34), 6'd63, lat, got);
    chk("rowwrap_lat", lat, 4); chk("rowwrap_x", int'(fx), 0); chk("rowwrap_y", int'(fy), 5);

    // Start forced to 41 and occupied -> wraps to cell 0.
    w = 0;
    while (m_lfsr[5:0] != 6'b101110 && w < 600) begin @(negedge clk); w++; end
    chk("lfsr_wait", int'(w < 600), 1);
    do_req(42'd1 << 41, 6'd63, lat, got);
    chk("boardwrap_lat", lat, 3); chk("boardwrap_x", int'(fx), 0); chk("boardwrap_y", int'(fy), 0);

    // Full board.
    do_req({42{1'b1}}, 6'd63, lat, got);
    chk("full_novalid", got, 0); chk("full_lat", lat, 43); chk("full_flag", int'(full), 1);
    chk("full_x", int'(fx), 0); chk("full_y", int'(fy), 0);
    repeat (4) @(negedge clk);
    chk("full_sticky", int'(full), 1);
    do_req(~(42'd1 << 20), 6'd63, lat, got);
    chk("refill_valid", got, 1); chk("refill_x", int'(fx), 6); chk("refill_y", int'(fy), 2);
    chk("refill_full", int'(full), 0);

    // Exclude the start cell on an empty board -> start+1.
    s = start_of(m_lfsr);
    e = (s + 1) % 42;
    do_req('0, 6'(s), lat, got);
    chk("excl_lat", lat, 3); chk("excl_x", int'(fx), e % 7); chk("excl_y", int'(fy), e / 7);

    // Extra request and body change mid-scan.
    body = ~(42'd1 << 10); excl = 6'd63; req = 1'b1;
    got = 0;
    for (int c = 1; c < 60; c++) begin
      @(negedge clk);
      req = (c == 3);
      if (c == 5) body = '0;
      if (fvalid) begin got = 1; break; end
    end
    req = 1'b0;
    chk("midscan_valid", got, 1); chk("midscan_x", int'(fx), 3); chk("midscan_y", int'(fy), 1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a long scan.
    body = {42{1'b1}}; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0); chk("abort_valid", int'(fvalid), 0);
    chk("abort_x", int'(fx), 6); chk("abort_y", int'(fy), 3);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_quiet", int'(fvalid), 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 200; it++) begin
      logic [41:0] b;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      case ($urandom_range(0, 3))
        0:       b = rand42() & rand42();
        1:       b = rand42();
        2:       b = rand42() | rand42() | rand42();
        default: b = ~(42'd1 << $urandom_range(0, 41));
      endcase
      if ($urandom_range(0, 15) == 0) b = {42{1'b1}};
      body = b; excl = 6'($urandom_range(0, 63)); req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      w = 0;
      while (m_busy && w < 50) begin
        req = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 3) == 0) body = rand42();
        @(negedge clk);
        w++;
      end
      req = 1'b0;
      $display("rand %0d body=%h excl=%0d -> x=%0d y=%0d full=%0b", it, b, excl, fx, fy, full);
      if (w >= 50) begin
        errors++; checks++;
        $display("FAIL rand_timeout iter=%0d got busy=%0b want 0", it, busy);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
